// File: rtl/fuzz_vector_sequencer.sv
// Applies an LFSR-generated stimulus sequence to a fuzz target and folds each response
// into a MISR signature so every tool can be compared on one final value.
module fuzz_vector_sequencer #(
  parameter int unsigned     IN_W    = 86,
  parameter int unsigned     OUT_W   = 81,
  parameter int unsigned     NUM_VEC = 21,
  parameter int unsigned     SETTLE  = 1,
  parameter logic [IN_W-1:0] POLY    = 86'h2000000000000000000061,
  parameter logic [IN_W-1:0] SEED    = 86'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_y,
  output logic             cap_valid,
  output logic [7:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature
);

  localparam int unsigned     CntW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE - 1);
  localparam logic [7:0]      LastIdx    = 8'(NUM_VEC - 1);
  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [IN_W-1:0] SeedEff    = (SEED == '0) ? IN_W'(1) : SEED;

  typedef enum logic [1:0] {StIdle, StApply, StCapture, StDone} state_e;

  state_e           state_q;
  logic [IN_W-1:0]  lfsr_q;
  logic [IN_W-1:0]  lfsr_next;
  logic [OUT_W-1:0] sig_q;
  logic [CntW-1:0]  settle_cnt_q;
  logic [7:0]       vec_idx_q;
  logic             cap_valid_q;
  logic             busy_q;
  logic             done_q;

  // The LFSR register drives the DUT directly, so dut_in is glitch-free.
  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lfsr_q       <= '0;
      sig_q        <= '0;
      settle_cnt_q <= '0;
      vec_idx_q    <= '0;
      cap_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_q       <= SeedEff;
            sig_q        <= '0;
            vec_idx_q    <= '0;
            settle_cnt_q <= SettleInit;
            busy_q       <= 1'b1;
            state_q      <= StApply;
          end
        end
        StApply: begin
          if (settle_cnt_q == '0) begin
            cap_valid_q <= 1'b1;
            state_q     <= StCapture;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end
        StCapture: begin
          sig_q <= {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ dut_y;
          if (vec_idx_q == LastIdx) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            vec_idx_q    <= vec_idx_q + 8'd1;
            lfsr_q       <= lfsr_next;
            settle_cnt_q <= SettleInit;
            state_q      <= StApply;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dut_in    = lfsr_q;
  assign signature = sig_q;
  assign vec_idx   = vec_idx_q;
  assign cap_valid = cap_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  num_vec_range_a: assert property (@(posedge clk) (NUM_VEC >= 1) && (NUM_VEC <= 256));
  settle_range_a:  assert property (@(posedge clk) SETTLE >= 1);

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed captures and run ends, monitors
// pop and compare whenever the sequencer strobes cap_valid or done.
module tb_fuzz_vector_sequencer;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] din;
    logic [7:0] sig;
  } cap_t;

  typedef struct {
    int         edge_n;
    logic [7:0] sig;
  } done_t;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       tie = 1'b0;
  logic [7:0] dut_in;
  logic [7:0] dut_y;
  logic       cap_valid;
  logic [7:0] vec_idx;
  logic       busy;
  logic       done;
  logic [7:0] signature;

  logic       start_s0 = 1'b0;
  logic [7:0] din_s0;
  logic       cap_s0;
  logic [7:0] idx_s0;
  logic       busy_s0;
  logic       done_s0;
  logic [7:0] sig_s0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s = 0;

  // Hand-derived: POLY B8 from seed 01, and MISR with y=dut_in or y=01.
  logic [7:0] din_tab [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
  logic [7:0] sig_own [5] = '{8'h01, 8'hBA, 8'h29, 8'h7C, 8'hEF};
  logic [7:0] sig_one [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};

  cap_t       cap_q [$];
  done_t      done_q [$];
  logic [7:0] s0_cap_q [$];
  done_t      s0_done_q [$];

  assign dut_y = tie ? 8'h01 : dut_in;

  fuzz_vector_sequencer #(
    .IN_W(8), .OUT_W(8), .NUM_VEC(5), .SETTLE(1), .POLY(8'hB8), .SEED(8'h01)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_y(dut_y),
    .cap_valid(cap_valid), .vec_idx(vec_idx), .busy(busy), .done(done),
    .signature(signature)
  );

  fuzz_vector_sequencer #(
    .IN_W(8), .OUT_W(8), .NUM_VEC(2), .SETTLE(3), .POLY(8'hB8), .SEED(8'h00)
  ) u_seed0 (
    .clk(clk), .rst_n(rst_n), .start(start_s0), .dut_in(din_s0), .dut_y(din_s0),
    .cap_valid(cap_s0), .vec_idx(idx_s0), .busy(busy_s0), .done(done_s0),
    .signature(sig_s0)
  );

  always #5 if (clk_en) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got strobe expected none", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut_in"}, dut_in, 0);
    check({tag, "_cap_valid"}, cap_valid, 0);
    check({tag, "_vec_idx"}, vec_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_signature"}, signature, 0);
  endtask

  // Queue one full run; the next posedge must sample start.
  task automatic push_run(input logic tie_one);
    done_t d;
    for (int i = 0; i < 5; i++) begin
      cap_t c;
      c.idx = 8'(i);
      c.din = din_tab[i];
      c.sig = tie_one ? sig_one[i] : sig_own[i];
      cap_q.push_back(c);
    end
    d.edge_n = cyc + 1 + 11;
    d.sig    = tie_one ? 8'h1F : 8'hEF;
    done_q.push_back(d);
  endtask

  logic       pend = 1'b0;
  logic [7:0] pend_sig;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("sig_after_cap", signature, pend_sig);
        pend = 1'b0;
      end
      if (cap_valid) begin
        if (cap_q.size() == 0) fail_unexpected("unexpected_cap");
        else begin
          cap_t c;
          c = cap_q.pop_front();
          check("cap_vec_idx", vec_idx, c.idx);
          check("cap_dut_in", dut_in, c.din);
          check("cap_busy", busy, 1);
          pend     = 1'b1;
          pend_sig = c.sig;
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_unexpected("unexpected_done");
        else begin
          done_t d;
          d = done_q.pop_front();
          check("done_edge", cyc, d.edge_n);
          check("done_signature", signature, d.sig);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cap_s0) begin
      if (s0_cap_q.size() == 0) fail_unexpected("s0_unexpected_cap");
      else check("s0_dut_in", din_s0, s0_cap_q.pop_front());
    end
    if (rst_n && done_s0) begin
      if (s0_done_q.size() == 0) fail_unexpected("s0_unexpected_done");
      else begin
        done_t d;
        d = s0_done_q.pop_front();
        check("s0_done_edge", cyc, d.edge_n);
        check("s0_signature", sig_s0, d.sig);
      end
    end
  end

  initial begin
    done_t d0;
    // Asynchronous reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Run A (y = dut_in) alongside the zero-seed instance.
    push_run(1'b0);
    s0_cap_q.push_back(8'h01);
    s0_cap_q.push_back(8'hB8);
    d0.edge_n = cyc + 1 + 9;
    d0.sig    = 8'hBA;
    s0_done_q.push_back(d0);
    s = cyc + 1;
    start = 1'b1;
    start_s0 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_s0 = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;  // busy: must be ignored
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;  // DONE cycle: ignored; held into the next IDLE cycle
    @(negedge clk);
    tie = 1'b1;
    push_run(1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("held_signature", signature, 8'h1F);
    check("idle_busy", busy, 0);
    check("held_dut_in", dut_in, 8'h17);

    // Run C: reset during APPLY of vector 2.
    tie = 1'b0;
    push_run(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun");
    cap_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Run D must reproduce run A exactly.
    push_run(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("rerun_signature", signature, 8'hEF);

    check("cap_queue_drained", cap_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("s0_queue_drained", s0_cap_q.size() + s0_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
